sic_dispatcher: RTL

// - Issue-side endpoint of the SIC instruction handshake.
// - Buffers renamed sic_packet entries from the issue stage in an in-order FIFO.
// - Hands each entry, oldest first, to one idle SIC. An idle SIC is one with req_instr high.
// - Drives each SIC's packet_in with a one-cycle valid pulse. Supports a whole-buffer flush on PC redirect.

---
 rtl/sic_dispatcher_pkg.sv | 36 +++
 rtl/sic_rr_picker.sv | 25 ++
 rtl/sic_dispatcher.sv | 107 ++++++++++
 3 files changed

// File: rtl/sic_dispatcher_pkg.sv
// Shared SIC packet layout, sizing constants and the rotate-priority pick
// helper used by the dispatcher's SIC arbiter.
package sic_dispatcher_pkg;

  localparam int unsigned PKT_NUM_PHY_REGS = 64;
  localparam int unsigned PKT_ID_WIDTH     = 8;
  localparam int unsigned PKT_NUM_ECRS     = 4;
  localparam int unsigned PREG_W           = $clog2(PKT_NUM_PHY_REGS);
  localparam int unsigned ECR_W            = $clog2(PKT_NUM_ECRS);
  localparam int unsigned RR_MAX           = 16;

  typedef struct packed {
    logic                    valid;
    logic [PKT_ID_WIDTH-1:0] issue_id;
    logic [PREG_W-1:0]       rd;
    logic [PREG_W-1:0]       rs1;
    logic [PREG_W-1:0]       rs2;
    logic [ECR_W-1:0]        ecr;
    logic [15:0]             imm;
  } sic_packet_t;

  // First set bit of elig scanning ptr, ptr+1, ... mod n; -1 when none.
  function automatic int rr_pick(input logic [RR_MAX-1:0] elig,
                                 input int unsigned ptr,
                                 input int unsigned n);
    int          r;
    int unsigned k;
    r = -1;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      k = (ptr + i) % n;
      if (r < 0 && i < n && elig[k]) r = int'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/sic_rr_picker.sv
// Combinational rotate-priority encoder: first eligible SIC starting at ptr.
module sic_rr_picker
  import sic_dispatcher_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [RR_MAX-1:0] elig_ext;
  int                pick;

  always_comb begin
    elig_ext          = '0;
    elig_ext[N-1:0]   = elig;
    pick              = rr_pick(elig_ext, 32'(ptr), N);
    found             = (pick >= 0);
    idx               = IW'(pick);
  end

endmodule

// File: rtl/sic_dispatcher.sv
// Issue-side SIC dispatcher: in-order packet FIFO feeding idle SICs one
// packet per cycle, round-robin, as single-cycle valid pulses.
module sic_dispatcher
  import sic_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_SICS     = 4,
  parameter int unsigned NUM_PHY_REGS = 64,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned NUM_ECRS     = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  sic_packet_t         in_pkt,
  input  logic                flush,
  input  logic [NUM_SICS-1:0] sic_req_instr,
  output sic_packet_t         sic_pkt [NUM_SICS],
  output logic [CNT_W-1:0]    fifo_count,
  output logic [31:0]         dispatch_cnt
);

  localparam int unsigned SIC_W = $clog2(NUM_SICS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  // The packet layout is fixed by the package; reject mismatched sizing.
  if (NUM_PHY_REGS != PKT_NUM_PHY_REGS || ID_WIDTH != PKT_ID_WIDTH ||
      NUM_ECRS != PKT_NUM_ECRS || NUM_SICS < 2 || NUM_SICS > RR_MAX ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_err
    $error("sic_dispatcher: unsupported parameter set");
  end

  sic_packet_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic [SIC_W-1:0]    rr_ptr;
  logic [NUM_SICS-1:0] elig;
  logic                pick_found;
  logic [SIC_W-1:0]    pick_idx;
  logic                push, fire;
  sic_packet_t         head_pkt;

  always_comb begin
    for (int unsigned k = 0; k < NUM_SICS; k++) begin
      elig[k] = sic_req_instr[k] && !sic_pkt[k].valid;
    end
  end

  sic_rr_picker #(.N(NUM_SICS)) u_picker (
    .elig  (elig),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    in_ready       = (count < CNT_W'(FIFO_DEPTH)) && !flush;
    push           = in_valid && in_ready;
    fire           = (count != '0) && pick_found && !flush;
    head_pkt       = mem[head];
    head_pkt.valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (fire) head <= head + 1'b1;
      if (push && !fire)      count <= count + 1'b1;
      else if (!push && fire) count <= count - 1'b1;
    end
  end

  // Flush needs no branch here: fire is already low, so every valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NUM_SICS; j++) sic_pkt[j] <= '0;
      rr_ptr       <= '0;
      dispatch_cnt <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_SICS; j++) begin
        sic_pkt[j].valid <= 1'b0;
        if (fire && pick_idx == SIC_W'(j)) sic_pkt[j] <= head_pkt;
      end
      if (fire) begin
        rr_ptr       <= (pick_idx == SIC_W'(NUM_SICS - 1)) ? '0 : pick_idx + 1'b1;
        dispatch_cnt <= dispatch_cnt + 32'd1;
      end
    end
  end

  assign fifo_count = count;

endmodule
